// File: rtl/bcd_sum_display_if.sv
// Bus between the bcdadd result source and the two-digit display stage.
interface bcd_sum_display_if;
  logic       load;
  logic       sum_tens;
  logic [3:0] sum_ones;
  logic [6:0] seg;
  logic [1:0] an;
  logic       disp_valid;
  logic       err;

  modport master (
    output load, sum_tens, sum_ones,
    input  seg, an, disp_valid, err
  );

  modport slave (
    input  load, sum_tens, sum_ones,
    output seg, an, disp_valid, err
  );
endinterface

// File: rtl/bcd_sum_display.sv
// Latches a two-digit BCD sum and scans it onto a multiplexed common-cathode
// 7-segment display with leading-zero blanking and invalid-digit flagging.
module bcd_sum_display #(
  parameter int SCAN_DIV = 4,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  bcd_sum_display_if.slave  bus
);

  localparam int PW = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
  localparam logic [PW-1:0] TERM = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SHOW_ONES = 2'b01,
    SHOW_TENS = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          r_tens;
  logic [3:0]    r_ones;
  logic          r_valid;
  logic          r_err;
  logic [6:0]    r_seg;
  logic [1:0]    r_an;
  logic [6:0]    w_seg;
  logic [1:0]    w_an;
  logic          w_ones_bad;

  // Anything above 9 falls through to the "E" glyph.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h79;
    endcase
  endfunction

  assign w_ones_bad = (r_ones > 4'd9);

  // Next-state and prescaler; a load inside a scan never disturbs the timing.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    case (r_state)
      IDLE: begin
        if (bus.load) begin
          w_state_nxt = SHOW_ONES;
          w_presc_nxt = {PW{1'b0}};
        end else begin
          w_state_nxt = IDLE;
          w_presc_nxt = {PW{1'b0}};
        end
      end
      SHOW_ONES, SHOW_TENS: begin
        if (r_presc == TERM) begin
          w_presc_nxt = {PW{1'b0}};
          w_state_nxt = (r_state == SHOW_ONES) ? SHOW_TENS : SHOW_ONES;
        end else begin
          w_presc_nxt = r_presc + PW'(1);
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_presc_nxt = {PW{1'b0}};
      end
    endcase
  end

  // Digit decode for the slot currently selected by the state register.
  always_comb begin
    w_seg = 7'h00;
    w_an  = 2'b00;
    case (r_state)
      SHOW_ONES: begin
        w_an  = 2'b01;
        w_seg = seg_decode(r_ones);
      end
      SHOW_TENS: begin
        if (w_ones_bad) begin
          w_an  = 2'b00;
          w_seg = 7'h00;
        end else if (!r_tens && LZ_BLANK) begin
          w_an  = 2'b00;
          w_seg = 7'h00;
        end else begin
          w_an  = 2'b10;
          w_seg = seg_decode({3'b000, r_tens});
        end
      end
      default: begin
        w_an  = 2'b00;
        w_seg = 7'h00;
      end
    endcase
  end

  // State, held digits and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_presc <= {PW{1'b0}};
      r_tens  <= 1'b0;
      r_ones  <= 4'd0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_seg   <= 7'h00;
      r_an    <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      if (bus.load) begin
        r_tens  <= bus.sum_tens;
        r_ones  <= bus.sum_ones;
        r_valid <= 1'b1;
      end else begin
        r_tens  <= r_tens;
        r_ones  <= r_ones;
        r_valid <= r_valid;
      end
      r_err <= w_ones_bad;
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.disp_valid = r_valid;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_bcd_sum_display.sv
// Random and directed stimulus against a time-based display model, run on
// two instances (SCAN_DIV=4 with blanking, SCAN_DIV=3 without).
module tb_bcd_sum_display;

  logic       clk = 1'b0;
  logic       d_rst = 1'b1;
  logic       d_load = 1'b0;
  logic       d_tens = 1'b0;
  logic [3:0] d_ones = 4'd0;

  int n_total = 0;
  int n_bad   = 0;

  bcd_sum_display_if u_if0 ();
  bcd_sum_display_if u_if1 ();

  assign u_if0.load = d_load;
  assign u_if0.sum_tens = d_tens;
  assign u_if0.sum_ones = d_ones;
  assign u_if1.load = d_load;
  assign u_if1.sum_tens = d_tens;
  assign u_if1.sum_ones = d_ones;

  bcd_sum_display #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) u_dut0 (.clk(clk), .rst(d_rst), .bus(u_if0.slave));
  bcd_sum_display #(.SCAN_DIV(3), .LZ_BLANK(1'b0)) u_dut1 (.clk(clk), .rst(d_rst), .bus(u_if1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: which slot is lit is purely a function of time since the first load.
  function automatic logic [8:0] model_out(input int sd, input bit lz, input int start,
                                           input int t, input logic tens, input logic [3:0] ones);
    logic [6:0] tab [10];
    int j;
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    if (start < 0) return 9'h000;
    j = t - 1 - start;
    if (((j / sd) % 2) == 0) begin
      if (ones > 4'd9) return {7'h79, 2'b01};
      return {tab[ones], 2'b01};
    end
    if (ones > 4'd9) return 9'h000;
    if (!tens && lz) return 9'h000;
    return {(tens ? 7'h06 : 7'h3F), 2'b10};
  endfunction

  int         cyc = 0;
  int         m_start = -1;
  logic       m_tens = 1'b0;
  logic [3:0] m_ones = 4'd0;
  logic       m_valid = 1'b0;
  logic       have_exp = 1'b0;
  logic [8:0] e_out0, e_out1;
  logic       e_valid, e_err;

  // Model update: expected outputs for this edge come from the pre-edge model state.
  always @(posedge clk) begin
    if (d_rst) begin
      e_out0  <= 9'h000;
      e_out1  <= 9'h000;
      e_valid <= 1'b0;
      e_err   <= 1'b0;
      m_start <= -1;
      m_tens  <= 1'b0;
      m_ones  <= 4'd0;
      m_valid <= 1'b0;
    end else begin
      e_out0  <= model_out(4, 1'b1, m_start, cyc, m_tens, m_ones);
      e_out1  <= model_out(3, 1'b0, m_start, cyc, m_tens, m_ones);
      e_valid <= m_valid | d_load;
      e_err   <= (m_ones > 4'd9);
      if (d_load) begin
        m_tens  <= d_tens;
        m_ones  <= d_ones;
        m_valid <= 1'b1;
        if (m_start < 0) m_start <= cyc;
      end
    end
    cyc      <= cyc + 1;
    have_exp <= 1'b1;
  end

  always @(negedge clk) begin
    if (have_exp) begin
      chk("seg0", {25'd0, u_if0.seg}, {25'd0, e_out0[8:2]});
      chk("an0", {30'd0, u_if0.an}, {30'd0, e_out0[1:0]});
      chk("valid0", {31'd0, u_if0.disp_valid}, {31'd0, e_valid});
      chk("err0", {31'd0, u_if0.err}, {31'd0, e_err});
      chk("seg1", {25'd0, u_if1.seg}, {25'd0, e_out1[8:2]});
      chk("an1", {30'd0, u_if1.an}, {30'd0, e_out1[1:0]});
      chk("valid1", {31'd0, u_if1.disp_valid}, {31'd0, e_valid});
      chk("err1", {31'd0, u_if1.err}, {31'd0, e_err});
      chk("an_not11", {31'd0, (u_if0.an == 2'b11) || (u_if1.an == 2'b11)}, 32'd0);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load(input logic t, input logic [3:0] o);
    d_tens = t;
    d_ones = o;
    d_load = 1'b1;
    tick(1);
    d_load = 1'b0;
  endtask

  initial begin
    logic [4:0] s;
    logic       c;
    logic [4:0] corr;
    tick(2);
    d_rst = 1'b0;
    tick(20);

    pulse_load(1'b1, 4'd5);
    tick(20);
    pulse_load(1'b0, 4'd7);
    tick(20);
    pulse_load(1'b0, 4'hC);
    tick(12);
    pulse_load(1'b1, 4'd2);
    tick(12);

    // Loads landing exactly on the four-cycle terminal count of instance 0.
    for (int k = 0; k < 3; k++) begin
      while (((cyc - m_start) % 4) != 0) tick(1);
      pulse_load(k[0], 4'(3 + k));
      tick(5);
    end

    // Reset colliding with a load mid-scan.
    tick(2);
    d_tens = 1'b1;
    d_ones = 4'd8;
    d_load = 1'b1;
    d_rst  = 1'b1;
    tick(1);
    d_load = 1'b0;
    d_rst  = 1'b0;
    tick(10);

    // Random loads, digits and occasional resets.
    for (int k = 0; k < 400; k++) begin
      d_rst  = ($urandom_range(0, 99) == 0);
      d_load = ($urandom_range(0, 5) == 0);
      d_tens = 1'($urandom_range(0, 1));
      d_ones = 4'($urandom_range(0, 15));
      tick(1);
    end
    d_rst  = 1'b0;
    d_load = 1'b0;
    tick(2);

    // Full a/b sweep through a behavioural bcdadd.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        s    = 5'(a + b);
        c    = (s > 5'd9);
        corr = c ? (s + 5'd6) : s;
        pulse_load(c, corr[3:0]);
        tick(9);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_sum_display.md
Name: bcd_sum_display

Overview:
Downstream display stage for the bcdadd BCD adder. It latches a two-digit BCD result, with the tens digit taken from Cout and the ones digit from S3..S0, on a load strobe. It then drives a time-multiplexed two-digit common-cathode 7-segment display with a scan prescaler, leading-zero blanking and invalid-digit flagging. All outputs are registered.

Parameters:
SCAN_DIV, 4, clock cycles each digit stays enabled; legal range is 2 or more; the prescaler width is the ceiling of log2(SCAN_DIV).
LZ_BLANK, 1, when 1 a zero tens digit is blanked; when 0 it is shown as "0".

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
load  input  1  one-cycle strobe that captures sum_tens and sum_ones
sum_tens  input  1  tens digit, driven from bcdadd Cout
sum_ones  input  4  ones digit, driven from bcdadd {S3,S2,S1,S0}
seg  output  7  segments {g,f,e,d,c,b,a}, active-high
an  output  2  digit enables, active-high; an[0] is the ones digit, an[1] is the tens digit
disp_valid  output  1  high once a value has been loaded since reset
err  output  1  high while the held ones digit is greater than 9

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. rst has priority over load.
- Reset state:
  - state = IDLE, prescaler = 0, held tens = 0, held ones = 0.
  - seg = 7'h00, an = 2'b00, disp_valid = 0, err = 0.
  - All values take effect at the first edge with rst=1.
- Capture: at an edge with load=1 and rst=0, the held registers take {sum_tens, sum_ones}. disp_valid is set at that edge and stays set until reset. err is the registered result of (held ones > 9).
- State machine:
  - States are IDLE, SHOW_ONES and SHOW_TENS.
  - IDLE to SHOW_ONES on load; the prescaler is forced to 0 on that transition.
  - In SHOW_ONES or SHOW_TENS the prescaler increments each cycle. At SCAN_DIV-1 it wraps to 0 and the state toggles between SHOW_ONES and SHOW_TENS.
  - A load while in a SHOW state updates the held value only. State and prescaler are not disturbed.
  - Load at the terminal count: the toggle and the capture both occur at the same edge.
  - The state never returns to IDLE except by rst.
- Output timing:
  - seg and an are registered decodes of (state, held values), so they lag the state by one cycle.
  - A load sampled at edge N gives an=01 with the new ones pattern at edge N+1.
  - an switches to 10 at edge N+SCAN_DIV+1.
  - Each digit is then enabled for exactly SCAN_DIV cycles, alternating.
- Decode (hex) of the seg pattern for each digit: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, E=79.
- IDLE: an=00, seg=00.
- SHOW_ONES: an=01.
  - If held ones is 9 or less, seg is the decode of that digit.
  - If held ones is greater than 9, seg=79 ("E").
- SHOW_TENS:
  - If err=1, an=00 and seg=00.
  - Otherwise, if held tens=0 and LZ_BLANK=1, an=00 and seg=00; the slot still lasts SCAN_DIV cycles.
  - Otherwise, an=10 and seg is the decode of the tens digit (06 for 1, 3F for an unblanked 0).
- an is never 11. seg is 00 whenever an=00.
- Reset mid-scan: at the next edge every register returns to its reset value, and a simultaneous load is discarded.

Test Plan:
1. Assert rst for 2 cycles, then run 20 cycles with load=0 -> seg=00, an=00, disp_valid=0 and err=0 throughout.
2. SCAN_DIV=4; pulse load with tens=1, ones=5 at edge N -> at edge N+1, an=01 and seg=6D for 4 cycles; at N+5, an=10 and seg=06 for 4 cycles; the pattern repeats; disp_valid=1 from N.
3. LZ_BLANK=1; load tens=0, ones=7 -> ones slot: an=01, seg=07; tens slot: an=00, seg=00, lasting 4 cycles. Rerun with LZ_BLANK=0 -> tens slot: an=10, seg=3F.
4. Load tens=0, ones=4'b1100 -> err=1; ones slot seg=79; tens slot blank. Then load tens=1, ones=2 -> err=0; slots show 5B and 06.
5. Pulse load at the prescaler terminal count -> the digit toggles at that edge and the new value is shown with no extra slot length. Assert rst together with load mid-scan -> next edge all outputs return to reset values, held digits are 0, and the load is ignored.
6. Connect the bcdadd outputs and sweep all 256 a/b combinations, loading each and waiting 2*SCAN_DIV+2 cycles -> observed digits match the reference BCD sum (decimal ones digit and carry); err=1 only for an invalid ones digit.
